// File: rtl/nx_node_loader_if.sv
// Message stream and core-load bus for nx_node_loader.
// master = upstream/stimulus side, slave = loader side.
interface nx_node_loader_if #(
  parameter int MSG_W  = 32,
  parameter int INST_W = 19,
  parameter int SLOT_W = 5,
  parameter int IDX_W  = 2
);
  logic [MSG_W-1:0]  msg_data;
  logic              msg_valid;
  logic              msg_ready;
  logic [INST_W-1:0] load_instr;
  logic [SLOT_W-1:0] load_slot;
  logic              load_last;
  logic              load_valid;
  logic              in_value;
  logic [IDX_W-1:0]  in_index;
  logic              in_valid;
  logic [SLOT_W:0]   loaded_count;
  logic              error;
  logic [2:0]        error_code;

  modport master (
    output msg_data, msg_valid,
    input  msg_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid, loaded_count, error, error_code
  );

  modport slave (
    input  msg_data, msg_valid,
    output msg_ready, load_instr, load_slot, load_last, load_valid,
           in_value, in_index, in_valid, loaded_count, error, error_code
  );
endinterface

// File: rtl/nx_node_loader.sv
// Node-core front-end: decodes inbound messages into instruction/input loads.
// Optional even-parity checking on every accepted word via NX_LOADER_PARITY_EN.
module nx_node_loader #(
  parameter int OP_W   = 4,
  parameter int REG_W  = 16,
  parameter int IO_W   = 4,
  parameter int SLOTS  = 32,
  parameter int INST_W = OP_W + 3*$clog2(REG_W) + 1 + $clog2(IO_W),
  parameter int MSG_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  nx_node_loader_if.slave     bus
);
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int IDX_W  = $clog2(IO_W);
  localparam int CNT_W  = SLOT_W + 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(SLOTS);

  typedef enum logic [1:0] {ST_LOAD, ST_ACTIVE, ST_ERROR} state_e;
  typedef enum logic [1:0] {MT_LOAD, MT_SIGNAL, MT_NOP, MT_ILLEGAL} msg_type_e;

  state_e            r_state;
  logic              r_ready;
  logic [SLOT_W-1:0] r_slot;
  logic [CNT_W-1:0]  r_count;
  logic [INST_W-1:0] r_load_instr;
  logic [SLOT_W-1:0] r_load_slot;
  logic              r_load_last;
  logic              r_load_valid;
  logic              r_in_value;
  logic [IDX_W-1:0]  r_in_index;
  logic              r_in_valid;
  logic              r_error;
  logic [2:0]        r_error_code;

  logic              w_xfer;
  msg_type_e         w_type;
  logic              w_last;
  logic              w_parity_ok;
  logic              w_do_load;
  logic              w_do_sig;
  logic [2:0]        w_err;

  assign w_xfer = bus.msg_valid && r_ready;
  assign w_type = msg_type_e'(bus.msg_data[MSG_W-1 -: 2]);
  assign w_last = bus.msg_data[MSG_W-3];

`ifdef NX_LOADER_PARITY_EN
  assign w_parity_ok = ~(^bus.msg_data);
`else
  logic w_unused_bits;
  assign w_unused_bits = ^bus.msg_data;
  assign w_parity_ok   = 1'b1;
`endif

  // Per-transfer decode; overflow is flagged while the load itself still issues.
  always_comb begin
    w_do_load = 1'b0;
    w_do_sig  = 1'b0;
    w_err     = 3'd0;
    if (w_xfer) begin
      if (!w_parity_ok) begin
        w_err = 3'd4;
      end else begin
        case (w_type)
          MT_LOAD: begin
            if (r_state == ST_LOAD) begin
              w_do_load = 1'b1;
              if (!w_last && r_slot == LAST_SLOT) w_err = 3'd3;
            end else begin
              w_err = 3'd2;
            end
          end
          MT_SIGNAL: w_do_sig = 1'b1;
          MT_NOP:    ;
          default:   w_err = 3'd1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_LOAD;
      r_ready      <= 1'b0;
      r_slot       <= '0;
      r_count      <= '0;
      r_load_instr <= '0;
      r_load_slot  <= '0;
      r_load_last  <= 1'b0;
      r_load_valid <= 1'b0;
      r_in_value   <= 1'b0;
      r_in_index   <= '0;
      r_in_valid   <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= '0;
    end else begin
      r_load_valid <= w_do_load;
      r_in_valid   <= w_do_sig;
      if (w_do_load) begin
        r_load_instr <= bus.msg_data[INST_W-1:0];
        r_load_slot  <= r_slot;
        // Overflow forces last so the core still leaves setup.
        r_load_last  <= w_last || (r_slot == LAST_SLOT);
        if (r_slot != LAST_SLOT) r_slot <= r_slot + 1'b1;
        if (r_count != FULL_CNT) r_count <= r_count + 1'b1;
        if (w_last) r_state <= ST_ACTIVE;
      end
      if (w_do_sig) begin
        r_in_index <= bus.msg_data[IDX_W-1:0];
        r_in_value <= bus.msg_data[IDX_W];
      end
      if (w_err != 3'd0) begin
        r_state <= ST_ERROR;
        r_ready <= 1'b0;
        r_error <= 1'b1;
        if (!r_error) r_error_code <= w_err;
      end else if (r_state != ST_ERROR) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign bus.msg_ready    = r_ready;
  assign bus.load_instr   = r_load_instr;
  assign bus.load_slot    = r_load_slot;
  assign bus.load_last    = r_load_last;
  assign bus.load_valid   = r_load_valid;
  assign bus.in_value     = r_in_value;
  assign bus.in_index     = r_in_index;
  assign bus.in_valid     = r_in_valid;
  assign bus.loaded_count = r_count;
  assign bus.error        = r_error;
  assign bus.error_code   = r_error_code;
endmodule

// File: tb/tb_nx_node_loader.sv
// Scoreboard bench for nx_node_loader: directed scenarios plus randomized streams.
`timescale 1ns/1ps
module tb_nx_node_loader;
  localparam int MSG_W  = 32;
  localparam int INST_W = 19;
  localparam int SLOTS  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_node_loader_if #(.MSG_W(MSG_W), .INST_W(INST_W), .SLOT_W(5), .IDX_W(2)) bus ();

  nx_node_loader #(.OP_W(4), .REG_W(16), .IO_W(4), .SLOTS(SLOTS), .MSG_W(MSG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          is_load;
    logic [18:0] instr;
    int          slot;
    bit          last;
    logic [1:0]  idx;
    bit          val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: program progress and first error only.
  int m_n;
  bit m_done;
  bit m_dead;
  int m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] typ, input logic last,
                                     input logic [18:0] pl, input bit bad);
    logic [31:0] m;
    m = $urandom;
    m[31:30] = typ;
    m[29] = last;
    if (typ == 2'd1) m[2:0] = pl[2:0];
    else             m[18:0] = pl;
`ifdef NX_LOADER_PARITY_EN
    m[28] = 1'b0;
    m[28] = ^m;
`endif
    if (bad) m[28] = ~m[28];
    return m;
  endfunction

  task automatic model_reset();
    m_n = 0; m_done = 0; m_dead = 0; m_err = 0;
  endtask

  task automatic raise(input int code);
    if (m_err == 0) m_err = code;
    m_dead = 1;
  endtask

  task automatic model_apply(input logic [31:0] m);
    exp_t e;
    e = '{is_load: 0, instr: '0, slot: 0, last: 0, idx: '0, val: 0};
`ifdef NX_LOADER_PARITY_EN
    if (^m) begin raise(4); return; end
`endif
    case (m[31:30])
      2'd0: begin
        if (m_done) raise(2);
        else begin
          e.is_load = 1; e.instr = m[18:0]; e.slot = m_n;
          e.last = m[29] || (m_n == SLOTS - 1);
          sb.push_back(e);
          m_n++;
          if (m[29]) m_done = 1;
          else if (m_n == SLOTS) raise(3);
        end
      end
      2'd1: begin
        e.idx = m[1:0]; e.val = m[2];
        sb.push_back(e);
      end
      2'd2: ;
      default: raise(1);
    endcase
  endtask

  task automatic send(input logic [31:0] m);
    @(negedge clk);
    bus.msg_data = m;
    bus.msg_valid = 1'b1;
    check("msg_ready", 64'(bus.msg_ready), 64'(!m_dead));
    if (!m_dead) model_apply(m);
    @(posedge clk);
  endtask

  task automatic check_status();
    check("error", 64'(bus.error), 64'(m_err != 0));
    check("error_code", 64'(bus.error_code), 64'(m_err));
    check("loaded_count", 64'(bus.loaded_count), 64'(m_n));
    check("ready_status", 64'(bus.msg_ready), 64'(!m_dead));
    check("strobes_pending", 64'(sb.size()), 64'd0);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.msg_valid = 1'b0;
    bus.msg_data = $urandom;
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    bus.msg_valid = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    check("rst_ready", 64'(bus.msg_ready), 64'd0);
    check("rst_strobes", 64'({bus.load_valid, bus.in_valid}), 64'd0);
    check("rst_err", 64'({bus.error, bus.error_code}), 64'd0);
    check("rst_data", 64'({bus.load_instr, bus.load_slot, bus.load_last,
                           bus.in_index, bus.in_value, bus.loaded_count}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.msg_ready), 64'd1);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      if (bus.load_valid && bus.in_valid) check("strobe_exclusive", 64'd1, 64'd0);
      if (bus.load_valid) begin
        if (sb.size() == 0 || !sb[0].is_load) begin
          checks++; errors++;
          $display("FAIL unexpected_load slot %0d instr %0h at %0t", bus.load_slot, bus.load_instr, $time);
        end else begin
          e = sb.pop_front();
          check("load_slot", 64'(bus.load_slot), 64'(e.slot));
          check("load_instr", 64'(bus.load_instr), 64'(e.instr));
          check("load_last", 64'(bus.load_last), 64'(e.last));
        end
      end
      if (bus.in_valid) begin
        if (sb.size() == 0 || sb[0].is_load) begin
          checks++; errors++;
          $display("FAIL unexpected_in index %0d value %0d at %0t", bus.in_index, bus.in_value, $time);
        end else begin
          e = sb.pop_front();
          check("in_index", 64'(bus.in_index), 64'(e.idx));
          check("in_value", 64'(bus.in_value), 64'(e.val));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.msg_valid = 1'b0;
    bus.msg_data  = '0;
    model_reset();
    do_reset();

    // Two-instruction program, then inputs while active.
    send(mk(2'd0, 1'b0, 19'h12345, 0));
    send(mk(2'd0, 1'b1, 19'h00001, 0));
    idle();
    send(mk(2'd1, 1'b0, 19'h6, 0));
    send(mk(2'd1, 1'b0, 19'h2, 0));
    send(mk(2'd2, 1'b0, 19'h0, 0));
    idle();
    // Late load, then an illegal word that must not be accepted.
    send(mk(2'd0, 1'b0, 19'h7abcd, 0));
    idle();
    send(mk(2'd3, 1'b0, 19'h0, 0));
    idle();

    // Overflow: 32 loads without last.
    do_reset();
    for (int i = 0; i < SLOTS; i++) send(mk(2'd0, 1'b0, 19'(i * 4099 + 7), 0));
    send(mk(2'd0, 1'b0, 19'h1, 0));
    idle();

    // Illegal type held on the bus.
    do_reset();
    for (int i = 0; i < 4; i++) send(mk(2'd3, 1'b0, 19'h0, 0));
    idle();
    do_reset();
    send(mk(2'd0, 1'b1, 19'h55555, 0));
    idle();

`ifdef NX_LOADER_PARITY_EN
    do_reset();
    begin
      logic [31:0] good;
      good = mk(2'd0, 1'b0, 19'h2468a, 0);
      send(good ^ 32'h1000_0000);
      idle();
      do_reset();
      send(good);
      idle();
    end
`endif

    // Randomized streams with gaps and occasional mid-stream reset.
    for (int r = 0; r < 12; r++) begin
      do_reset();
      for (int k = 0; k < int'($urandom_range(20, 70)); k++) begin
        int unsigned p;
        logic [1:0] typ;
        p = $urandom_range(0, 99);
        typ = (p < 55) ? 2'd0 : (p < 85) ? 2'd1 : (p < 97) ? 2'd2 : 2'd3;
        send(mk(typ, ($urandom_range(0, 11) == 0), 19'($urandom),
                ($urandom_range(0, 49) == 0)));
        p = $urandom_range(0, 99);
        if (p < 3) do_reset();
        else if (p < 25) idle();
      end
      idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
